dff_bank_arbiter: RTL
=====================

// Module: dff_bank_arbiter
// PURPOSE
//   Round-robin write arbiter for one shared WIDTH-bit register (a bank of d_ff cells).
//   NREQ requesters offer data with valid/ready; the arbiter grants one at a time and commits it to q.
//   It is the single writer of the bank: requesters never drive the flops directly.
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   WIDTH  8   register width in bits
//   CNT_W  16  width of each grant counter (DFF_ARB_STATS_EN only)
// PORTS
//   clk        in   1              clock; all logic on rising edge
//   rst        in   1              reset, synchronous, active-high
//   req_valid  in   NREQ           requester i has data on req_data[i*WIDTH +: WIDTH]
//   req_data   in   NREQ*WIDTH     packed write data, requester i at slice i
//   req_ready  out  NREQ           one-hot; transfer when req_valid[i] & req_ready[i]
//   q          out  WIDTH          current register contents
//   q_owner    out  $clog2(NREQ)   index of requester that last wrote q
//   upd        out  1              1-cycle pulse, q updated this cycle
//   busy       out  1              FSM not in ST_IDLE
//   grant_cnt  out  NREQ*CNT_W     per-requester committed-write counters (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=1 at edge): q=0, q_owner=0, upd=0, req_ready=0, busy=0, rr ptr=0, state=ST_IDLE, counters=0.
//   Reset wins over every other event, including mid-grant/mid-commit: no write, no upd.
//   FSM:
//   - ST_IDLE: if |req_valid, pick winner w = first i with req_valid[i] scanning ptr, ptr+1, ... mod NREQ;
//     register w, go ST_GRANT. Otherwise stay.
//   - ST_GRANT: req_ready[w]=1 for exactly this cycle. If req_valid[w]=1: latch req_data slice w into hold,
//     go ST_COMMIT. If req_valid[w]=0 (requester withdrew): abort, ptr unchanged, go ST_IDLE.
//   - ST_COMMIT: q<=hold, q_owner<=w, upd=1, ptr<=(w+1) mod NREQ, go ST_IDLE.
//   Latency: valid seen in IDLE at cycle n -> ready at n+1 -> q/upd/q_owner registered, visible at n+2.
//   Throughput: one write per 3 cycles max; req_ready never asserted outside ST_GRANT.
//   Requester rule: hold valid and data stable until ready; valid changes in IDLE are re-sampled each cycle.
//   Fairness: all NREQ continuously valid -> grant order ptr, ptr+1, ... wrapping NREQ-1 -> 0.
//   Pointer wrap: w=NREQ-1 -> ptr=0. Non-power-of-2 NREQ supported.
//   q holds value between commits; upd=0 except in ST_COMMIT cycle.
// CONFIGURATION
//   DFF_ARB_STATS_EN defined: grant_cnt[i] increments by 1 in each ST_COMMIT with w=i;
//     saturates at 2^CNT_W-1 (no wrap); aborted grants not counted; cleared by rst.
//   Not defined: no counter flops; grant_cnt tied to 0; port list unchanged.
// STRUCTURE
//   Package dff_arb_pkg: typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_COMMIT} arb_state_t;
//     localparam helpers for index width (IDX_W = $clog2(NREQ)).
//   Sub-module dff_arb_rr_pick: combinational round-robin picker (req, ptr -> any, winner idx).
//   Top holds FSM, ptr, hold register, q/q_owner flops, optional counters.
// TESTING
//   1 Reset: rst=1 two cycles with req_valid=4'b1111 -> q=0, req_ready=0, upd=0, busy=0, grant_cnt all 0.
//   2 Single req: req_valid=4'b0100, slice2=8'hA5 at n -> req_ready=4'b0100 at n+1, q=8'hA5,
//     q_owner=2, upd=1 at n+2.
//   3 Round-robin: req_valid=4'b1111, slice i = 8'h10+i held -> commits q=10,11,12,13,10 every 3 cycles.
//   4 Withdraw: req_valid[1] dropped in ST_GRANT -> no upd, q unchanged, next grant still requester 1.
//   5 Reset mid-op: rst=1 in ST_COMMIT cycle with hold=8'h3C -> q=0, upd=0, ptr=0 next cycle.
//   6 Stats (DFF_ARB_STATS_EN, CNT_W=2): 5 commits from requester 0 -> grant_cnt[0]=3 (saturated);
//     without macro grant_cnt=0 throughout.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the dff_bank_arbiter round-robin register writer.
// Optional grant statistics are enabled by defining DFF_ARB_STATS_EN.
package dff_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_COMMIT
    } arb_state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // Index width for n requesters; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NREQ (non-power-of-2 NREQ supported).
module dff_arb_rr_pick
    import dff_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    int               cand;
    logic [IDX_W-1:0] candIdx;

    // Scan ptr, ptr+1, ... and keep only the first hit.
    always_comb begin
        any_o   = 1'b0;
        idx_o   = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            candIdx = cand[IDX_W-1:0];
            if (!any_o && req_i[candIdx]) begin
                any_o = 1'b1;
                idx_o = candIdx;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin single-writer arbiter for one shared WIDTH-bit register bank.
// Define DFF_ARB_STATS_EN to build saturating per-requester commit counters.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        q,
    output logic [$clog2(NREQ)-1:0] q_owner,
    output logic                    upd,
    output logic                    busy,
    output logic [NREQ*CNT_W-1:0]   grant_cnt
);

    localparam int IDX_W = idx_width(NREQ);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic             pickAny;
    logic [IDX_W-1:0] pickIdx;
    logic [WIDTH-1:0] winnerData;
    logic             inCommit;

    dff_arb_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .any_o (pickAny),
        .idx_o (pickIdx)
    );

    assign winnerData = req_data[int'(winner_q)*WIDTH +: WIDTH];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        q_d      = q_q;
        case (state_q)
            ST_IDLE: begin
                if (pickAny) begin
                    winner_d = pickIdx;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A withdrawn request aborts without moving the pointer.
                if (req_valid[winner_q]) begin
                    hold_d  = winnerData;
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                q_d     = hold_q;
                owner_d = winner_q;
                ptr_d   = (winner_q == IDX_W'(NREQ - 1)) ? '0 : winner_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            owner_q  <= '0;
            hold_q   <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            q_q      <= q_d;
        end
    end

    // The commit cycle already presents the new value; reset suppresses it.
    assign inCommit = (state_q == ST_COMMIT) && !rst;
    assign upd      = inCommit;
    assign busy     = (state_q != ST_IDLE);
    assign q        = inCommit ? hold_q : q_q;
    assign q_owner  = inCommit ? winner_q : owner_q;

    always_comb begin
        req_ready = '0;
        if ((state_q == ST_GRANT) && !rst) begin
            req_ready[winner_q] = 1'b1;
        end
    end

`ifdef DFF_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NREQ];
    logic [CNT_W-1:0] cnt_d [NREQ];

    // Saturating counters; aborted grants never reach ST_COMMIT.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((state_q == ST_COMMIT) && (winner_q == IDX_W'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

endmodule
